// File: rtl/mii_hub_arbiter.sv
// Two-port MII hub: forwards one MAC's transmit stream to the other, signals
// collisions, enforces an inter-frame gap and keeps saturating status counters.
module mii_hub_arbiter #(
  parameter int unsigned IFG_NIBBLES = 24,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             txrx_clk,
  input  logic             rst,
  input  logic [3:0]       a_txd,
  input  logic             a_txen,
  input  logic             a_txerr,
  input  logic [3:0]       b_txd,
  input  logic             b_txen,
  input  logic             b_txerr,
  output logic [3:0]       a_rxd,
  output logic             a_rxdv,
  output logic             a_rxerr,
  output logic             a_coll,
  output logic             a_crs,
  output logic [3:0]       b_rxd,
  output logic             b_rxdv,
  output logic             b_rxerr,
  output logic             b_coll,
  output logic             b_crs,
  output logic [CNT_W-1:0] frames_a,
  output logic [CNT_W-1:0] frames_b,
  output logic [CNT_W-1:0] collisions,
  output logic [CNT_W-1:0] ifg_violations
);

  localparam int unsigned IFG_W = (IFG_NIBBLES > 1) ? $clog2(IFG_NIBBLES) : 1;
  localparam int unsigned SUM_W = CNT_W + 1;
  localparam logic [IFG_W-1:0] IFG_LOAD = IFG_W'(IFG_NIBBLES - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_A_TX,
    ST_B_TX,
    ST_COLL,
    ST_IFG
  } state_t;

  state_t           r_state;
  logic [IFG_W-1:0] r_ifg_cnt;
  logic             r_a_txen_d;
  logic             r_b_txen_d;

  state_t           w_state_nxt;
  logic [IFG_W-1:0] w_ifg_cnt_nxt;
  logic [3:0]       w_a_rxd;
  logic             w_a_rxdv;
  logic             w_a_rxerr;
  logic             w_a_coll;
  logic             w_a_crs;
  logic [3:0]       w_b_rxd;
  logic             w_b_rxdv;
  logic             w_b_rxerr;
  logic             w_b_coll;
  logic             w_b_crs;
  logic [1:0]       w_inc_fa;
  logic [1:0]       w_inc_fb;
  logic [1:0]       w_inc_col;
  logic [1:0]       w_inc_viol;
  logic             w_a_rise;
  logic             w_b_rise;

  assign w_a_rise = a_txen & ~r_a_txen_d;
  assign w_b_rise = b_txen & ~r_b_txen_d;

  function automatic logic [CNT_W-1:0] f_sat_add(input logic [CNT_W-1:0] cnt,
                                                 input logic [1:0]       inc);
    logic [SUM_W-1:0] sum;
    sum = {1'b0, cnt} + SUM_W'(inc);
    return sum[CNT_W] ? '1 : sum[CNT_W-1:0];
  endfunction

  // Next state and next registered outputs, decided from the current state and inputs
  always_comb begin
    w_state_nxt   = r_state;
    w_ifg_cnt_nxt = r_ifg_cnt;
    w_a_rxd       = 4'h0;
    w_a_rxdv      = 1'b0;
    w_a_rxerr     = 1'b0;
    w_a_coll      = 1'b0;
    w_a_crs       = 1'b0;
    w_b_rxd       = 4'h0;
    w_b_rxdv      = 1'b0;
    w_b_rxerr     = 1'b0;
    w_b_coll      = 1'b0;
    w_b_crs       = 1'b0;
    w_inc_fa      = 2'd0;
    w_inc_fb      = 2'd0;
    w_inc_col     = 2'd0;
    w_inc_viol    = 2'd0;

    case (r_state)
      ST_IDLE: begin
        if (a_txen && b_txen) begin
          w_state_nxt = ST_COLL;
          w_inc_col   = 2'd1;
          {w_a_coll, w_b_coll, w_a_crs, w_b_crs} = 4'hF;
        end else if (a_txen) begin
          w_state_nxt = ST_A_TX;
          {w_a_crs, w_b_crs} = 2'b11;
          w_b_rxd   = a_txd;
          w_b_rxdv  = a_txen;
          w_b_rxerr = a_txerr & a_txen;
        end else if (b_txen) begin
          w_state_nxt = ST_B_TX;
          {w_a_crs, w_b_crs} = 2'b11;
          w_a_rxd   = b_txd;
          w_a_rxdv  = b_txen;
          w_a_rxerr = b_txerr & b_txen;
        end
      end
      ST_A_TX: begin
        {w_a_crs, w_b_crs} = 2'b11;
        if (b_txen) begin
          w_state_nxt = ST_COLL;
          w_inc_col   = 2'd1;
          {w_a_coll, w_b_coll} = 2'b11;
        end else if (!a_txen) begin
          w_state_nxt   = ST_IFG;
          w_ifg_cnt_nxt = IFG_LOAD;
          w_inc_fa      = 2'd1;
        end else begin
          w_b_rxd   = a_txd;
          w_b_rxdv  = a_txen;
          w_b_rxerr = a_txerr & a_txen;
        end
      end
      ST_B_TX: begin
        {w_a_crs, w_b_crs} = 2'b11;
        if (a_txen) begin
          w_state_nxt = ST_COLL;
          w_inc_col   = 2'd1;
          {w_a_coll, w_b_coll} = 2'b11;
        end else if (!b_txen) begin
          w_state_nxt   = ST_IFG;
          w_ifg_cnt_nxt = IFG_LOAD;
          w_inc_fb      = 2'd1;
        end else begin
          w_a_rxd   = b_txd;
          w_a_rxdv  = b_txen;
          w_a_rxerr = b_txerr & b_txen;
        end
      end
      ST_COLL: begin
        {w_a_crs, w_b_crs} = 2'b11;
        if (!a_txen && !b_txen) begin
          w_state_nxt   = ST_IFG;
          w_ifg_cnt_nxt = IFG_LOAD;
        end else begin
          {w_a_coll, w_b_coll} = 2'b11;
        end
      end
      ST_IFG: begin
        // Frames started inside the gap are dropped, counted, and keep the gap open
        w_inc_viol = 2'(w_a_rise) + 2'(w_b_rise);
        if (r_ifg_cnt != '0) begin
          {w_a_crs, w_b_crs} = 2'b11;
          w_ifg_cnt_nxt = r_ifg_cnt - IFG_W'(1);
        end else if (a_txen || b_txen) begin
          {w_a_crs, w_b_crs} = 2'b11;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge txrx_clk) begin
    if (rst) begin
      r_state        <= ST_IDLE;
      r_ifg_cnt      <= '0;
      r_a_txen_d     <= 1'b0;
      r_b_txen_d     <= 1'b0;
      a_rxd          <= 4'h0;
      a_rxdv         <= 1'b0;
      a_rxerr        <= 1'b0;
      a_coll         <= 1'b0;
      a_crs          <= 1'b0;
      b_rxd          <= 4'h0;
      b_rxdv         <= 1'b0;
      b_rxerr        <= 1'b0;
      b_coll         <= 1'b0;
      b_crs          <= 1'b0;
      frames_a       <= '0;
      frames_b       <= '0;
      collisions     <= '0;
      ifg_violations <= '0;
    end else begin
      r_state        <= w_state_nxt;
      r_ifg_cnt      <= w_ifg_cnt_nxt;
      r_a_txen_d     <= a_txen;
      r_b_txen_d     <= b_txen;
      a_rxd          <= w_a_rxd;
      a_rxdv         <= w_a_rxdv;
      a_rxerr        <= w_a_rxerr;
      a_coll         <= w_a_coll;
      a_crs          <= w_a_crs;
      b_rxd          <= w_b_rxd;
      b_rxdv         <= w_b_rxdv;
      b_rxerr        <= w_b_rxerr;
      b_coll         <= w_b_coll;
      b_crs          <= w_b_crs;
      frames_a       <= f_sat_add(frames_a, w_inc_fa);
      frames_b       <= f_sat_add(frames_b, w_inc_fb);
      collisions     <= f_sat_add(collisions, w_inc_col);
      ifg_violations <= f_sat_add(ifg_violations, w_inc_viol);
    end
  end

endmodule

// File: tb/tb_mii_hub_arbiter.sv
// Directed scoreboard bench for mii_hub_arbiter: default instance plus a
// CNT_W=2 instance sharing the same stimulus to exercise counter saturation.
module tb_mii_hub_arbiter;

  typedef struct packed {
    logic [3:0] a_rxd;
    logic       a_rxdv;
    logic       a_rxerr;
    logic       a_coll;
    logic       a_crs;
    logic [3:0] b_rxd;
    logic       b_rxdv;
    logic       b_rxerr;
    logic       b_coll;
    logic       b_crs;
  } out_t;

  logic       txrx_clk = 1'b0;
  logic       rst;
  logic [3:0] a_txd, b_txd;
  logic       a_txen, a_txerr, b_txen, b_txerr;

  logic [3:0]  a_rxd, b_rxd;
  logic        a_rxdv, a_rxerr, a_coll, a_crs, b_rxdv, b_rxerr, b_coll, b_crs;
  logic [15:0] frames_a, frames_b, collisions, ifg_violations;

  logic [3:0] d2_a_rxd, d2_b_rxd;
  logic       d2_a_rxdv, d2_a_rxerr, d2_a_coll, d2_a_crs;
  logic       d2_b_rxdv, d2_b_rxerr, d2_b_coll, d2_b_crs;
  logic [1:0] d2_frames_a, d2_frames_b, d2_collisions, d2_ifg_violations;

  int   n_vec = 0;
  int   n_err = 0;
  out_t sb_q[$];

  always #5 txrx_clk = ~txrx_clk;

  mii_hub_arbiter dut (
    .txrx_clk(txrx_clk), .rst(rst),
    .a_txd(a_txd), .a_txen(a_txen), .a_txerr(a_txerr),
    .b_txd(b_txd), .b_txen(b_txen), .b_txerr(b_txerr),
    .a_rxd(a_rxd), .a_rxdv(a_rxdv), .a_rxerr(a_rxerr), .a_coll(a_coll), .a_crs(a_crs),
    .b_rxd(b_rxd), .b_rxdv(b_rxdv), .b_rxerr(b_rxerr), .b_coll(b_coll), .b_crs(b_crs),
    .frames_a(frames_a), .frames_b(frames_b),
    .collisions(collisions), .ifg_violations(ifg_violations)
  );

  mii_hub_arbiter #(.IFG_NIBBLES(24), .CNT_W(2)) dut2 (
    .txrx_clk(txrx_clk), .rst(rst),
    .a_txd(a_txd), .a_txen(a_txen), .a_txerr(a_txerr),
    .b_txd(b_txd), .b_txen(b_txen), .b_txerr(b_txerr),
    .a_rxd(d2_a_rxd), .a_rxdv(d2_a_rxdv), .a_rxerr(d2_a_rxerr), .a_coll(d2_a_coll),
    .a_crs(d2_a_crs),
    .b_rxd(d2_b_rxd), .b_rxdv(d2_b_rxdv), .b_rxerr(d2_b_rxerr), .b_coll(d2_b_coll),
    .b_crs(d2_b_crs),
    .frames_a(d2_frames_a), .frames_b(d2_frames_b),
    .collisions(d2_collisions), .ifg_violations(d2_ifg_violations)
  );

  function automatic out_t e_idle();
    return '0;
  endfunction

  function automatic out_t e_crs();
    out_t e;
    e = '0;
    e.a_crs = 1'b1;
    e.b_crs = 1'b1;
    return e;
  endfunction

  function automatic out_t e_coll();
    out_t e;
    e = e_crs();
    e.a_coll = 1'b1;
    e.b_coll = 1'b1;
    return e;
  endfunction

  function automatic out_t e_ab(input logic [3:0] d, input logic err);
    out_t e;
    e = e_crs();
    e.b_rxd   = d;
    e.b_rxdv  = 1'b1;
    e.b_rxerr = err;
    return e;
  endfunction

  function automatic out_t e_ba(input logic [3:0] d, input logic err);
    out_t e;
    e = e_crs();
    e.a_rxd   = d;
    e.a_rxdv  = 1'b1;
    e.a_rxerr = err;
    return e;
  endfunction

  task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Pops one expected output word per clock once stimulus has queued it
  always @(posedge txrx_clk) begin
    out_t exp, obs1, obs2;
    #1;
    if (sb_q.size() > 0) begin
      exp  = sb_q.pop_front();
      obs1 = {a_rxd, a_rxdv, a_rxerr, a_coll, a_crs, b_rxd, b_rxdv, b_rxerr, b_coll, b_crs};
      obs2 = {d2_a_rxd, d2_a_rxdv, d2_a_rxerr, d2_a_coll, d2_a_crs,
              d2_b_rxd, d2_b_rxdv, d2_b_rxerr, d2_b_coll, d2_b_crs};
      cmp("outputs", 32'(obs1), 32'(exp));
      cmp("outputs_w2", 32'(obs2), 32'(exp));
    end
  end

  task automatic step(input logic ae, input logic [3:0] ad, input logic aerr,
                      input logic be, input logic [3:0] bd, input logic berr,
                      input logic r, input out_t exp);
    @(negedge txrx_clk);
    a_txen = ae; a_txd = ad; a_txerr = aerr;
    b_txen = be; b_txd = bd; b_txerr = berr;
    rst = r;
    sb_q.push_back(exp);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 4'h0, 0, 0, 4'h0, 0, 0, e_idle());
  endtask

  task automatic gap(input int n);
    for (int i = 0; i < n; i++) step(0, 4'h0, 0, 0, 4'h0, 0, 0, e_crs());
  endtask

  // Counters updated by the most recently driven step are checked after its edge
  task automatic chk_cnt(input string tag, input int fa, input int fb, input int col,
                         input int viol);
    @(posedge txrx_clk);
    #2;
    cmp({tag, ".frames_a"}, 32'(frames_a), 32'(fa));
    cmp({tag, ".frames_b"}, 32'(frames_b), 32'(fb));
    cmp({tag, ".collisions"}, 32'(collisions), 32'(col));
    cmp({tag, ".ifg_violations"}, 32'(ifg_violations), 32'(viol));
  endtask

  task automatic chk_w2(input string tag, input int fa);
    @(posedge txrx_clk);
    #2;
    cmp({tag, ".frames_a_w2"}, 32'(d2_frames_a), 32'(fa));
  endtask

  task automatic clean_a_frame();
    step(1, 4'h1, 0, 0, 4'h0, 0, 0, e_ab(4'h1, 0));
    step(1, 4'h2, 0, 0, 4'h0, 0, 0, e_ab(4'h2, 0));
    gap(24);
    idle(1);
  endtask

  initial begin
    rst = 1'b1;
    a_txd = 4'h0; a_txen = 1'b0; a_txerr = 1'b0;
    b_txd = 4'h0; b_txen = 1'b0; b_txerr = 1'b0;

    // Reset state
    step(0, 4'h0, 0, 0, 4'h0, 0, 1, e_idle());
    step(0, 4'h0, 0, 0, 4'h0, 0, 1, e_idle());
    chk_cnt("reset", 0, 0, 0, 0);
    idle(1);
    step(0, 4'hC, 1, 0, 4'h3, 1, 0, e_idle());
    idle(1);

    // Clean 16-nibble A frame, one errored nibble, then a 24-cycle gap
    for (int i = 0; i < 16; i++)
      step(1, 4'(i), (i == 9), 0, 4'h0, 0, 0, e_ab(4'(i), (i == 9)));
    gap(1);
    chk_cnt("a_frame", 1, 0, 0, 0);
    gap(23);
    idle(1);

    // Simultaneous start: collision for 8 cycles
    for (int i = 0; i < 8; i++) step(1, 4'hA, 0, 1, 4'h5, 0, 0, e_coll());
    gap(1);
    chk_cnt("sim_coll", 1, 0, 1, 0);
    gap(23);
    idle(1);

    // B joins 5 cycles into an A frame
    for (int i = 0; i < 5; i++) step(1, 4'(i + 1), 0, 0, 4'h0, 0, 0, e_ab(4'(i + 1), 0));
    for (int i = 0; i < 4; i++) step(1, 4'h6, 0, 1, 4'h3, 0, 0, e_coll());
    step(0, 4'h0, 0, 1, 4'h3, 0, 0, e_coll());
    gap(1);
    chk_cnt("late_coll", 1, 0, 2, 0);
    gap(23);
    idle(1);

    // Clean B frame
    for (int i = 0; i < 4; i++)
      step(0, 4'h0, 0, 1, 4'(8 + i), (i == 2), 0, e_ba(4'(8 + i), (i == 2)));
    gap(1);
    chk_cnt("b_frame", 1, 1, 2, 0);
    gap(23);
    idle(1);

    // B starts 3 cycles into the gap and stays up past the gap's end
    for (int i = 0; i < 4; i++) step(1, 4'(i), 0, 0, 4'h0, 0, 0, e_ab(4'(i), 0));
    gap(3);
    for (int i = 0; i < 30; i++) begin
      step(0, 4'h0, 0, 1, 4'h7, 0, 0, e_crs());
      if (i == 0) chk_cnt("ifg_viol", 2, 1, 2, 1);
    end
    idle(2);
    chk_cnt("ifg_done", 2, 1, 2, 1);

    // Reset mid-frame, A still transmitting afterwards
    for (int i = 0; i < 3; i++) step(1, 4'(i), 0, 0, 4'h0, 0, 0, e_ab(4'(i), 0));
    step(1, 4'h3, 0, 0, 4'h0, 0, 1, e_idle());
    chk_cnt("mid_rst", 0, 0, 0, 0);
    for (int i = 4; i < 8; i++) step(1, 4'(i), 0, 0, 4'h0, 0, 0, e_ab(4'(i), 0));
    gap(1);
    chk_cnt("post_rst", 1, 0, 0, 0);
    gap(23);
    idle(1);

    // Saturation of the 2-bit counter instance
    clean_a_frame();
    clean_a_frame();
    chk_w2("w2_three", 3);
    chk_cnt("three", 3, 0, 0, 0);
    clean_a_frame();
    clean_a_frame();
    chk_cnt("five", 5, 0, 0, 0);
    chk_w2("w2_sat", 3);

    @(posedge txrx_clk);
    #3;
    cmp("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
